// File: rtl/burst_address_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// burst_address_sequencer_pkg
// Shared definitions for the burst address sequencer and its address core:
//   - access size codes (byte / halfword / word)
//   - addressing mode codes (LIN wraps inside a window, SEQ plain increment)
//   - burst-length codes BURST1..BURSTPAGE
//   - sequencer state encoding
//   - bl_decode(): burst-length code -> beat count
//   - size_legal(): true for the three supported access sizes
// -----------------------------------------------------------------------------
package burst_address_sequencer_pkg;

  localparam int ADDR_W = 8;
  localparam int CNT_W  = 9;

  localparam logic [2:0] SIZE_B  = 3'd1;
  localparam logic [2:0] SIZE_HW = 3'd2;
  localparam logic [2:0] SIZE_W  = 3'd4;

  localparam logic ADDR_MODE_LIN = 1'b1;
  localparam logic ADDR_MODE_SEQ = 1'b0;

  localparam logic [2:0] BURST1    = 3'b000;
  localparam logic [2:0] BURST2    = 3'b001;
  localparam logic [2:0] BURST4    = 3'b010;
  localparam logic [2:0] BURST8    = 3'b011;
  localparam logic [2:0] BURST16   = 3'b100;
  localparam logic [2:0] BURST32   = 3'b101;
  localparam logic [2:0] BURST64   = 3'b110;
  localparam logic [2:0] BURSTPAGE = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_DONE   = 2'd2
  } state_e;

  // Codes 0..6 are powers of two; the page code is 256 beats rather than 128.
  function automatic logic [CNT_W-1:0] bl_decode(input logic [2:0] code);
    logic [CNT_W-1:0] beats;
    if (code == BURSTPAGE) beats = CNT_W'(256);
    else                   beats = CNT_W'(1) << code;
    return beats;
  endfunction

  function automatic logic size_legal(input logic [2:0] size);
    return (size == SIZE_B) || (size == SIZE_HW) || (size == SIZE_W);
  endfunction

endpackage

// File: rtl/burst_address_sequencer_addr_gen_core.sv
// -----------------------------------------------------------------------------
// AddressGeneratorCore
// Purely combinational next-beat address generator.
// Ports:
//   AddrIn            in  ADDR_WIDTH  current beat address
//   SizeIn            in  3           access size in bytes (1, 2, 4)
//   AddrMode          in  1           1 = LIN (wrap inside window), 0 = SEQ
//   BurstLengthConfig in  3           burst-length code (see package)
//   AddrOut           out ADDR_WIDTH  address of the following beat
// SEQ: AddrIn + Size, modulo 2^ADDR_WIDTH.
// LIN: AddrIn + Size, but only the bits inside the aligned window of
//      BL*Size bytes change; the bits above the window are held. A window
//      as large as the address space (page bursts) degenerates to SEQ.
// -----------------------------------------------------------------------------
module AddressGeneratorCore
  import burst_address_sequencer_pkg::*;
#(
  parameter int ADDR_WIDTH = 8
) (
  input  logic [ADDR_WIDTH-1:0] AddrIn,
  input  logic [2:0]            SizeIn,
  input  logic                  AddrMode,
  input  logic [2:0]            BurstLengthConfig,
  output logic [ADDR_WIDTH-1:0] AddrOut
);

  // Beat count (up to 256) times size (up to 4) needs 11 bits; one spare.
  localparam int WIN_W = CNT_W + 3;
  localparam logic [WIN_W-1:0] SPAN = WIN_W'(1) << ADDR_WIDTH;

  logic [WIN_W-1:0]      window;
  logic [ADDR_WIDTH-1:0] wrap_mask;
  logic [ADDR_WIDTH-1:0] incr_addr;

  always_comb begin
    window    = {3'b000, bl_decode(BurstLengthConfig)} * {{(WIN_W-3){1'b0}}, SizeIn};
    incr_addr = AddrIn + {{(ADDR_WIDTH-3){1'b0}}, SizeIn};
    // Windows covering the whole address space wrap naturally at the top.
    if (window >= SPAN) wrap_mask = '1;
    else                wrap_mask = ADDR_WIDTH'(window - WIN_W'(1));

    if (AddrMode == ADDR_MODE_LIN)
      AddrOut = (AddrIn & ~wrap_mask) | (incr_addr & wrap_mask);
    else
      AddrOut = incr_addr;
  end

endmodule

// File: rtl/burst_address_sequencer.sv
// -----------------------------------------------------------------------------
// burst_address_sequencer
// Registered burst driver around AddressGeneratorCore. Captures one burst
// request and then issues one address beat per accepted handshake.
// Ports:
//   Clk, Reset (async, active-high)
//   Start, AddrStart[7:0], SizeIn[2:0], AddrMode, BurstLengthConfig[2:0]
//                                   burst request and its configuration
//   Abort                           terminate the burst in progress
//   AddrReady                       downstream accepts AddrOut this cycle
//   AddrOut[7:0], AddrValid         beat address and its valid
//   BeatCount[8:0], LastBeat        0-based beat index, final-beat flag
//   Busy, Done, Err                 burst in progress, end pulse, bad size pulse
//   state_dbg[1:0]                  current FSM state (state_e encoding)
// Handshake: a beat transfers on a rising edge where AddrValid and AddrReady
// are both high. While AddrValid is high and AddrReady low, AddrOut,
// BeatCount and LastBeat are held stable; AddrValid never drops without a
// transfer except on Abort.
// -----------------------------------------------------------------------------
module burst_address_sequencer
  import burst_address_sequencer_pkg::*;
#(
  parameter int ADDR_WIDTH = 8,
  parameter int CNT_WIDTH  = 9
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic                  Start,
  input  logic [ADDR_WIDTH-1:0] AddrStart,
  input  logic [2:0]            SizeIn,
  input  logic                  AddrMode,
  input  logic [2:0]            BurstLengthConfig,
  input  logic                  Abort,
  input  logic                  AddrReady,
  output logic [ADDR_WIDTH-1:0] AddrOut,
  output logic                  AddrValid,
  output logic [CNT_WIDTH-1:0]  BeatCount,
  output logic                  LastBeat,
  output logic                  Busy,
  output logic                  Done,
  output logic                  Err,
  output logic [1:0]            state_dbg
);

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
  logic                  valid_q, valid_d;
  logic                  last_q, last_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  err_q, err_d;
  logic [2:0]            size_q, size_d;
  logic                  mode_q, mode_d;
  logic [2:0]            blc_q, blc_d;

  logic [ADDR_WIDTH-1:0] core_addr;
  logic [CNT_WIDTH-1:0]  bl_m1;        // final beat index of the captured burst
  logic [CNT_WIDTH-1:0]  start_bl_m1;  // final beat index of the request on the bus
  logic [CNT_WIDTH-1:0]  cnt_inc;

  // The core always sees the captured configuration and the live address
  // register, so its output is the address of the beat after this one.
  AddressGeneratorCore #(
    .ADDR_WIDTH (ADDR_WIDTH)
  ) AddrGenCore (
    .AddrIn            (addr_q),
    .SizeIn            (size_q),
    .AddrMode          (mode_q),
    .BurstLengthConfig (blc_q),
    .AddrOut           (core_addr)
  );

  always_comb begin
    bl_m1       = CNT_WIDTH'(bl_decode(blc_q)) - CNT_WIDTH'(1);
    start_bl_m1 = CNT_WIDTH'(bl_decode(BurstLengthConfig)) - CNT_WIDTH'(1);
    cnt_inc     = cnt_q + CNT_WIDTH'(1);

    state_d = state_q;
    addr_d  = addr_q;
    cnt_d   = cnt_q;
    valid_d = valid_q;
    last_d  = last_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    size_d  = size_q;
    mode_d  = mode_q;
    blc_d   = blc_q;

    case (state_q)
      ST_IDLE: begin
        // Abort has no meaning here, so a simultaneous Start simply wins.
        if (Start) begin
          if (size_legal(SizeIn)) begin
            size_d  = SizeIn;
            mode_d  = AddrMode;
            blc_d   = BurstLengthConfig;
            addr_d  = AddrStart;
            cnt_d   = '0;
            valid_d = 1'b1;
            busy_d  = 1'b1;
            last_d  = (start_bl_m1 == '0);
            state_d = ST_ACTIVE;
          end else begin
            err_d = 1'b1;
          end
        end
      end

      ST_ACTIVE: begin
        // Abort beats the handshake: the beat on the bus is not counted.
        if (Abort || (AddrReady && (cnt_q == bl_m1))) begin
          valid_d = 1'b0;
          last_d  = 1'b0;
          done_d  = 1'b1;
          state_d = ST_DONE;
        end else if (AddrReady) begin
          addr_d = core_addr;
          cnt_d  = cnt_inc;
          last_d = (cnt_inc == bl_m1);
        end
      end

      ST_DONE: begin
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end

      default: begin
        valid_d = 1'b0;
        last_d  = 1'b0;
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      size_q  <= '0;
      mode_q  <= 1'b0;
      blc_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      last_q  <= last_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
      size_q  <= size_d;
      mode_q  <= mode_d;
      blc_q   <= blc_d;
    end
  end

  assign AddrOut   = addr_q;
  assign AddrValid = valid_q;
  assign BeatCount = cnt_q;
  assign LastBeat  = last_q;
  assign Busy      = busy_q;
  assign Done      = done_q;
  assign Err       = err_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_burst_address_sequencer.sv
module tb_burst_address_sequencer;

  logic       Clk;
  logic       Reset;
  logic       Start;
  logic [7:0] AddrStart;
  logic [2:0] SizeIn;
  logic       AddrMode;
  logic [2:0] BurstLengthConfig;
  logic       Abort;
  logic       AddrReady;
  logic [7:0] AddrOut;
  logic       AddrValid;
  logic [8:0] BeatCount;
  logic       LastBeat;
  logic       Busy;
  logic       Done;
  logic       Err;
  logic [1:0] state_dbg;

  int n_cmp = 0;
  int n_err = 0;

  burst_address_sequencer dut (
    .Clk               (Clk),
    .Reset             (Reset),
    .Start             (Start),
    .AddrStart         (AddrStart),
    .SizeIn            (SizeIn),
    .AddrMode          (AddrMode),
    .BurstLengthConfig (BurstLengthConfig),
    .Abort             (Abort),
    .AddrReady         (AddrReady),
    .AddrOut           (AddrOut),
    .AddrValid         (AddrValid),
    .BeatCount         (BeatCount),
    .LastBeat          (LastBeat),
    .Busy              (Busy),
    .Done              (Done),
    .Err               (Err),
    .state_dbg         (state_dbg)
  );

  // ---------------- clock / reset ----------------
  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout want completion");
    $fatal(1, "watchdog expired");
  end

  // ---------------- vector table ----------------
  typedef struct {
    logic       start;
    logic [7:0] a;
    logic [2:0] sz;
    logic       md;
    logic [2:0] blc;
    logic       abort;
    logic       ready;
    logic       valid;
    logic [7:0] addr;
    logic [8:0] cnt;
    logic       last;
    logic       busy;
    logic       done;
    logic       err;
  } vec_t;

  vec_t vecs[$];

  function automatic void v(input logic start, input logic [7:0] a, input logic [2:0] sz,
                            input logic md, input logic [2:0] blc, input logic abort,
                            input logic ready, input logic valid, input logic [7:0] addr,
                            input logic [8:0] cnt, input logic last, input logic busy,
                            input logic done, input logic err);
    vec_t r;
    r.start = start; r.a = a; r.sz = sz; r.md = md; r.blc = blc; r.abort = abort;
    r.ready = ready; r.valid = valid; r.addr = addr; r.cnt = cnt; r.last = last;
    r.busy = busy; r.done = done; r.err = err;
    vecs.push_back(r);
  endfunction

  // ---------------- scoreboard ----------------
  logic [7:0] exp_q[$];

  task automatic check(input string name, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s[%0d]: got 0x%0h want 0x%0h", name, idx, act, exp);
    end
  endtask

  task automatic check_all_zero(input string name);
    check({name, "_addr"},  0, 32'(AddrOut),   32'h0);
    check({name, "_valid"}, 0, 32'(AddrValid), 32'h0);
    check({name, "_cnt"},   0, 32'(BeatCount), 32'h0);
    check({name, "_last"},  0, 32'(LastBeat),  32'h0);
    check({name, "_busy"},  0, 32'(Busy),      32'h0);
    check({name, "_done"},  0, 32'(Done),      32'h0);
    check({name, "_err"},   0, 32'(Err),       32'h0);
    check({name, "_state"}, 0, 32'(state_dbg), 32'h0);
  endtask

  // ---------------- driver ----------------
  task automatic drive_idle();
    Start = 1'b0; AddrStart = 8'h00; SizeIn = 3'd0; AddrMode = 1'b0;
    BurstLengthConfig = 3'd0; Abort = 1'b0; AddrReady = 1'b0;
  endtask

  task automatic apply_vec(input int i);
    @(negedge Clk);
    Start = vecs[i].start; AddrStart = vecs[i].a; SizeIn = vecs[i].sz;
    AddrMode = vecs[i].md; BurstLengthConfig = vecs[i].blc;
    Abort = vecs[i].abort; AddrReady = vecs[i].ready;
    @(posedge Clk);
    #1;
    check("valid", i, 32'(AddrValid), 32'(vecs[i].valid));
    check("addr",  i, 32'(AddrOut),   32'(vecs[i].addr));
    check("cnt",   i, 32'(BeatCount), 32'(vecs[i].cnt));
    check("last",  i, 32'(LastBeat),  32'(vecs[i].last));
    check("busy",  i, 32'(Busy),      32'(vecs[i].busy));
    check("done",  i, 32'(Done),      32'(vecs[i].done));
    check("err",   i, 32'(Err),       32'(vecs[i].err));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int beats;
    int done_cnt;
    int max_cnt;
    logic [7:0] exp_a;

    drive_idle();
    Reset = 1'b1;
    repeat (2) @(posedge Clk);
    #1;
    check_all_zero("reset");
    @(negedge Clk);
    Reset = 1'b0;

    // BURST4 LIN halfword from A6: window 8 bytes at A0.
    v(1, 8'hA6, 3'd2, 1, 3'd2, 0, 1,  1, 8'hA6, 9'd0, 0, 1, 0, 0);
    v(0, 8'h00, 3'd0, 0, 3'd0, 0, 1,  1, 8'hA0, 9'd1, 0, 1, 0, 0);
    v(0, 8'h00, 3'd0, 0, 3'd0, 0, 1,  1, 8'hA2, 9'd2, 0, 1, 0, 0);
    v(0, 8'h00, 3'd0, 0, 3'd0, 0, 1,  1, 8'hA4, 9'd3, 1, 1, 0, 0);
    v(0, 8'h00, 3'd0, 0, 3'd0, 0, 1,  0, 8'hA4, 9'd3, 0, 1, 1, 0);
    // Start during DONE is dropped.
    v(1, 8'h33, 3'd1, 0, 3'd0, 0, 1,  0, 8'hA4, 9'd3, 0, 0, 0, 0);

    // BURST8 SEQ byte from A4, Start with Abort in IDLE, ready toggling,
    // config inputs scrambled during the burst.
    v(1, 8'hA4, 3'd1, 0, 3'd3, 1, 0,  1, 8'hA4, 9'd0, 0, 1, 0, 0);
    for (int b = 1; b <= 7; b++) begin
      v(0, 8'h5A, 3'd4, 1, 3'd0, 0, 1,  1, 8'hA4 + 8'(b), 9'(b), (b == 7), 1, 0, 0);
      v(0, 8'h5A, 3'd4, 1, 3'd0, 0, 0,  1, 8'hA4 + 8'(b), 9'(b), (b == 7), 1, 0, 0);
    end
    v(0, 8'h00, 3'd0, 0, 3'd0, 0, 1,  0, 8'hAB, 9'd7, 0, 1, 1, 0);
    v(0, 8'h00, 3'd0, 0, 3'd0, 0, 0,  0, 8'hAB, 9'd7, 0, 0, 0, 0);

    // BURST32 SEQ halfword from A6, abort while beat 5 (B0) is on the bus.
    v(1, 8'hA6, 3'd2, 0, 3'd5, 0, 1,  1, 8'hA6, 9'd0, 0, 1, 0, 0);
    for (int b = 1; b <= 5; b++)
      v(0, 8'h00, 3'd1, 1, 3'd7, 0, 1,  1, 8'hA6 + 8'(2 * b), 9'(b), 0, 1, 0, 0);
    v(0, 8'h00, 3'd0, 0, 3'd0, 1, 1,  0, 8'hB0, 9'd5, 0, 1, 1, 0);
    v(0, 8'h00, 3'd0, 0, 3'd0, 1, 1,  0, 8'hB0, 9'd5, 0, 0, 0, 0);
    v(0, 8'h00, 3'd0, 0, 3'd0, 1, 1,  0, 8'hB0, 9'd5, 0, 0, 0, 0);

    // Illegal sizes raise a one-cycle Err and start nothing.
    v(1, 8'h55, 3'd3, 0, 3'd0, 0, 1,  0, 8'hB0, 9'd5, 0, 0, 0, 1);
    v(0, 8'h00, 3'd0, 0, 3'd0, 0, 1,  0, 8'hB0, 9'd5, 0, 0, 0, 0);
    v(1, 8'h55, 3'd0, 0, 3'd0, 0, 1,  0, 8'hB0, 9'd5, 0, 0, 0, 1);

    // BURST2 SEQ word from 10; a second Start while active is ignored.
    v(1, 8'h10, 3'd4, 0, 3'd1, 0, 0,  1, 8'h10, 9'd0, 0, 1, 0, 0);
    v(1, 8'h80, 3'd1, 0, 3'd0, 0, 0,  1, 8'h10, 9'd0, 0, 1, 0, 0);
    v(1, 8'h80, 3'd1, 0, 3'd0, 0, 1,  1, 8'h14, 9'd1, 1, 1, 0, 0);
    v(0, 8'h00, 3'd0, 0, 3'd0, 0, 1,  0, 8'h14, 9'd1, 0, 1, 1, 0);
    v(0, 8'h00, 3'd0, 0, 3'd0, 0, 1,  0, 8'h14, 9'd1, 0, 0, 0, 0);

    // BURST1 LIN byte: LastBeat on the first valid cycle, held over a stall.
    v(1, 8'h7F, 3'd1, 1, 3'd0, 0, 0,  1, 8'h7F, 9'd0, 1, 1, 0, 0);
    v(0, 8'h00, 3'd0, 0, 3'd0, 0, 0,  1, 8'h7F, 9'd0, 1, 1, 0, 0);
    v(0, 8'h00, 3'd0, 0, 3'd0, 0, 1,  0, 8'h7F, 9'd0, 0, 1, 1, 0);
    v(0, 8'h00, 3'd0, 0, 3'd0, 0, 1,  0, 8'h7F, 9'd0, 0, 0, 0, 0);

    // BURST8 LIN word from 3C: window 32 bytes at 20, abort on beat 2.
    v(1, 8'h3C, 3'd4, 1, 3'd3, 0, 1,  1, 8'h3C, 9'd0, 0, 1, 0, 0);
    v(0, 8'h00, 3'd0, 0, 3'd0, 0, 1,  1, 8'h20, 9'd1, 0, 1, 0, 0);
    v(0, 8'h00, 3'd0, 0, 3'd0, 0, 1,  1, 8'h24, 9'd2, 0, 1, 0, 0);
    v(0, 8'h00, 3'd0, 0, 3'd0, 1, 0,  0, 8'h24, 9'd2, 0, 1, 1, 0);
    v(0, 8'h00, 3'd0, 0, 3'd0, 0, 0,  0, 8'h24, 9'd2, 0, 0, 0, 0);

    foreach (vecs[i]) apply_vec(i);

    // ---- Page burst, SEQ word from A0: 256 beats, wraps FC -> 00 ----
    for (int i = 0; i < 256; i++) begin
      exp_a = 8'hA0 + 8'(4 * i);
      exp_q.push_back(exp_a);
    end
    @(negedge Clk);
    Start = 1'b1; AddrStart = 8'hA0; SizeIn = 3'd4; AddrMode = 1'b0;
    BurstLengthConfig = 3'b111; AddrReady = 1'b1;
    beats = 0; done_cnt = 0; max_cnt = 0;
    for (int cyc = 0; cyc < 300; cyc++) begin
      @(posedge Clk);
      #1;
      Start = 1'b0;
      if (AddrValid) begin
        if (exp_q.size() == 0) begin
          check("page_extra_beat", beats, 32'(AddrOut), 32'hFFFF_FFFF);
        end else begin
          exp_a = exp_q.pop_front();
          check("page_addr", beats, 32'(AddrOut), 32'(exp_a));
        end
        check("page_cnt",  beats, 32'(BeatCount), 32'(beats));
        check("page_last", beats, 32'(LastBeat),  32'(beats == 255));
        if (32'(BeatCount) > max_cnt) max_cnt = 32'(BeatCount);
        beats++;
      end
      if (Done) begin
        done_cnt++;
        break;
      end
    end
    check("page_beats",    0, 32'(beats),    32'd256);
    check("page_done_cnt", 0, 32'(done_cnt), 32'd1);
    check("page_max_cnt",  0, 32'(max_cnt),  32'd255);
    check("page_q_empty",  0, 32'(exp_q.size()), 32'd0);
    @(posedge Clk);
    #1;
    check("page_idle_busy", 0, 32'(Busy), 32'h0);
    check("page_idle_done", 0, 32'(Done), 32'h0);

    // ---- Reset asserted between edges in the middle of a burst ----
    @(negedge Clk);
    Start = 1'b1; AddrStart = 8'h40; SizeIn = 3'd1; AddrMode = 1'b0;
    BurstLengthConfig = 3'b100; AddrReady = 1'b1;
    @(posedge Clk);
    #1;
    Start = 1'b0;
    repeat (3) @(posedge Clk);
    #1;
    check("mid_addr", 0, 32'(AddrOut),   32'h43);
    check("mid_cnt",  0, 32'(BeatCount), 32'd3);
    #2;
    Reset = 1'b1;
    #1;
    check_all_zero("async_reset");
    @(negedge Clk);
    Reset = 1'b0;
    drive_idle();
    @(posedge Clk);
    #1;
    check_all_zero("after_reset");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
